// File: rtl/can_frame_tx_if.sv
// ---------------------------------------------------------------------------
// can_frame_tx_if
// Host request and CAN bus signals for the transmit core.
//   tx_req / tx_id / tx_dlc / tx_data / bit_stuffing_EN : frame request from host
//   bus_rx  : resolved wired-AND bus value read back by the core
//   bus_tx  : value the core drives onto the bus (1 = recessive)
//   tx_busy, tx_done, arb_lost, ack_err, bit_err : status and one-cycle pulses
// master = host/bus side, slave = transmit core.
// ---------------------------------------------------------------------------
interface can_frame_tx_if;
    logic        tx_req;
    logic [10:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        bit_stuffing_EN;
    logic        bus_rx;
    logic        bus_tx;
    logic        tx_busy;
    logic        tx_done;
    logic        arb_lost;
    logic        ack_err;
    logic        bit_err;

    modport master (
        output tx_req, tx_id, tx_dlc, tx_data, bit_stuffing_EN, bus_rx,
        input  bus_tx, tx_busy, tx_done, arb_lost, ack_err, bit_err
    );

    modport slave (
        input  tx_req, tx_id, tx_dlc, tx_data, bit_stuffing_EN, bus_rx,
        output bus_tx, tx_busy, tx_done, arb_lost, ack_err, bit_err
    );
endinterface

// File: rtl/can_frame_tx.sv
// ---------------------------------------------------------------------------
// can_frame_tx
// Serialises one standard CAN data frame per request onto the wired-AND bus,
// one bit per clk, with bit stuffing, CRC-15, arbitration/bit error checking
// and ACK slot sampling.
//   clk   : bit clock
//   reset : asynchronous, active-low
//   bus   : can_frame_tx_if.slave (host request, bus_tx/bus_rx, status pulses)
// Parameter IFS_BITS: recessive intermission bits after EOF.
// ---------------------------------------------------------------------------
module can_frame_tx #(
    parameter int unsigned IFS_BITS = 3
) (
    input logic           clk,
    input logic           reset,
    can_frame_tx_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
        ST_CRC_DEL, ST_ACK_SLOT, ST_ACK_DEL, ST_EOF, ST_IFS
    } state_e;

    localparam logic [14:0] CRC_POLY = 15'h4599;
    localparam logic [7:0]  IFS_LAST = 8'(IFS_BITS - 1);

    // state_q/cnt_q name the last non-stuff bit launched; stuff_q marks that
    // the bit currently on the bus is a stuff bit inserted after it.
    state_e      state_q, state_d, next_field, state_adv;
    logic [7:0]  cnt_q, cnt_d;
    logic [81:0] sr_q, sr_d;            // ID, RTR, IDE, r0, DLC, payload
    logic [14:0] crc_q, crc_d;
    logic [2:0]  run_q, run_d;
    logic        stuff_q, stuff_d;
    logic        stuff_en_q, stuff_en_d;
    logic [3:0]  nbytes_q, nbytes_d;
    logic        bus_tx_q, bus_tx_d;
    logic        done_q, done_d, arb_q, arb_d, ack_q, ack_d, berr_q, berr_d;
    logic        field_last, in_stuff_region, nb;
    logic [7:0]  data_last;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] r;
        r = {c[13:0], 1'b0};
        if (b ^ c[14]) r = r ^ CRC_POLY;
        return r;
    endfunction

    assign data_last       = {1'b0, nbytes_q, 3'b000} - 8'd1;
    assign in_stuff_region = (state_q == ST_ARB) || (state_q == ST_CTRL) ||
                             (state_q == ST_DATA) || (state_q == ST_CRC);

    always_comb begin
        field_last = 1'b1;
        next_field = ST_IDLE;
        case (state_q)
            ST_ARB:      begin field_last = (cnt_q == 8'd12);     next_field = ST_CTRL; end
            ST_CTRL:     begin field_last = (cnt_q == 8'd5);
                               next_field = (nbytes_q != 4'd0) ? ST_DATA : ST_CRC; end
            ST_DATA:     begin field_last = (cnt_q == data_last); next_field = ST_CRC; end
            ST_CRC:      begin field_last = (cnt_q == 8'd14);     next_field = ST_CRC_DEL; end
            ST_CRC_DEL:  next_field = ST_ACK_SLOT;
            ST_ACK_SLOT: next_field = ST_ACK_DEL;
            ST_ACK_DEL:  next_field = ST_EOF;
            ST_EOF:      begin field_last = (cnt_q == 8'd6);      next_field = ST_IFS; end
            ST_IFS:      begin field_last = (cnt_q == IFS_LAST);  next_field = ST_IDLE; end
            default:     next_field = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        crc_d      = crc_q;
        run_d      = run_q;
        stuff_d    = 1'b0;
        stuff_en_d = stuff_en_q;
        nbytes_d   = nbytes_q;
        bus_tx_d   = bus_tx_q;
        done_d     = 1'b0;
        arb_d      = 1'b0;
        ack_d      = 1'b0;
        berr_d     = 1'b0;
        state_adv  = state_q;
        nb         = 1'b1;

        if (state_q == ST_IDLE) begin
            if (bus.tx_req) begin
                // SOF goes out at the accepting edge; it is dominant, so the
                // CRC after shifting it in is still zero.
                state_d    = ST_ARB;
                cnt_d      = '0;
                sr_d       = {bus.tx_id, 3'b000, bus.tx_dlc, bus.tx_data};
                crc_d      = '0;
                run_d      = 3'd1;
                bus_tx_d   = 1'b0;
                stuff_en_d = bus.bit_stuffing_EN;
                nbytes_d   = (bus.tx_dlc > 4'd8) ? 4'd8 : bus.tx_dlc;
            end
        end else begin
            // Readback of the bit launched at the previous edge.
            if (state_q == ST_ARB && !stuff_q) begin
                arb_d  = bus_tx_q & ~bus.bus_rx;
                berr_d = ~bus_tx_q & bus.bus_rx;
            end else if (state_q == ST_ACK_SLOT) begin
                ack_d  = bus.bus_rx;
            end else begin
                berr_d = bus.bus_rx ^ bus_tx_q;
            end

            if (arb_d || ack_d || berr_d) begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                run_d    = '0;
                bus_tx_d = 1'b1;
            end else if (stuff_en_q && in_stuff_region && run_q == 3'd5) begin
                stuff_d  = 1'b1;
                bus_tx_d = ~bus_tx_q;
                run_d    = 3'd1;
            end else begin
                if (field_last) begin
                    state_adv = next_field;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                end
                state_d = state_adv;
                case (state_adv)
                    ST_ARB, ST_CTRL, ST_DATA: begin
                        nb    = sr_q[81];
                        sr_d  = {sr_q[80:0], 1'b0};
                        crc_d = crc_step(crc_q, sr_q[81]);
                    end
                    ST_CRC: begin
                        nb    = crc_q[14];
                        crc_d = {crc_q[13:0], 1'b0};
                    end
                    ST_IDLE: done_d = 1'b1;
                    default: nb = 1'b1;
                endcase
                bus_tx_d = nb;
                if (stuff_en_q && (state_adv == ST_ARB || state_adv == ST_CTRL ||
                                   state_adv == ST_DATA || state_adv == ST_CRC))
                    run_d = (nb == bus_tx_q) ? run_q + 3'd1 : 3'd1;
                else
                    run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            crc_q      <= '0;
            run_q      <= '0;
            stuff_q    <= 1'b0;
            stuff_en_q <= 1'b0;
            nbytes_q   <= '0;
            bus_tx_q   <= 1'b1;
            done_q     <= 1'b0;
            arb_q      <= 1'b0;
            ack_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            crc_q      <= crc_d;
            run_q      <= run_d;
            stuff_q    <= stuff_d;
            stuff_en_q <= stuff_en_d;
            nbytes_q   <= nbytes_d;
            bus_tx_q   <= bus_tx_d;
            done_q     <= done_d;
            arb_q      <= arb_d;
            ack_q      <= ack_d;
            berr_q     <= berr_d;
        end
    end

    assign bus.bus_tx   = bus_tx_q;
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign bus.tx_done  = done_q;
    assign bus.arb_lost = arb_q;
    assign bus.ack_err  = ack_q;
    assign bus.bit_err  = berr_q;
endmodule

// File: tb/tb_can_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_can_frame_tx
// Builds each expected frame from the field rules (unstuffed bit list, CRC
// over it, stuffing pass, fixed tail), emulates the wired-AND bus and checks
// bus_tx / status every bit time plus the terminating pulse.
// ---------------------------------------------------------------------------
module tb_can_frame_tx;
    localparam int IFS = 3;
    localparam int K_ARB = 0, K_OTH = 1, K_ACK = 2;
    localparam int F_ARB = 0, F_CTRL = 1, F_DATA = 2, F_CRC = 3, F_TAIL = 4;

    logic clk = 1'b0;
    logic reset;
    logic rx_drive;
    int   n_vec = 0;
    int   n_bad = 0;

    can_frame_tx_if ifc();
    assign ifc.bus_rx = ifc.bus_tx & rx_drive;

    can_frame_tx #(.IFS_BITS(IFS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    bit          exp_bits[$];
    int          exp_kind[$];
    int          exp_field[$];
    logic [10:0] m_id;
    logic [3:0]  m_dlc;
    logic [63:0] m_data;
    bit          m_sen;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return 8'({ifc.bus_tx, ifc.tx_busy, ifc.tx_done, ifc.arb_lost, ifc.ack_err, ifc.bit_err});
    endfunction

    task automatic push_u(inout bit u[$], inout int uk[$], inout int uf[$],
                          input bit b, input int k, input int f);
        u.push_back(b); uk.push_back(k); uf.push_back(f);
    endtask

    task automatic push_e(input bit b, input int k, input int f);
        exp_bits.push_back(b); exp_kind.push_back(k); exp_field.push_back(f);
    endtask

    task automatic build_model(input logic [10:0] id, input logic [3:0] dlc,
                               input logic [63:0] data, input bit sen);
        bit u[$];
        int uk[$];
        int uf[$];
        logic [14:0] crc;
        logic [63:0] d;
        int n, run;
        bit last, nx;
        m_id = id; m_dlc = dlc; m_data = data; m_sen = sen;
        exp_bits.delete(); exp_kind.delete(); exp_field.delete();
        push_u(u, uk, uf, 1'b0, K_ARB, F_ARB);
        for (int i = 10; i >= 0; i--) push_u(u, uk, uf, id[i], K_ARB, F_ARB);
        push_u(u, uk, uf, 1'b0, K_ARB, F_ARB);
        push_u(u, uk, uf, 1'b0, K_OTH, F_CTRL);
        push_u(u, uk, uf, 1'b0, K_OTH, F_CTRL);
        for (int i = 3; i >= 0; i--) push_u(u, uk, uf, dlc[i], K_OTH, F_CTRL);
        n = (dlc > 4'd8) ? 8 : int'(dlc);
        d = data;
        for (int i = 0; i < 8 * n; i++) begin
            push_u(u, uk, uf, d[63], K_OTH, F_DATA);
            d = d << 1;
        end
        crc = '0;
        foreach (u[i]) begin
            nx  = u[i] ^ crc[14];
            crc = crc << 1;
            if (nx) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) push_u(u, uk, uf, crc[i], K_OTH, F_CRC);
        run = 0; last = 1'b0;
        foreach (u[i]) begin
            push_e(u[i], uk[i], uf[i]);
            if (run > 0 && u[i] == last) run++;
            else run = 1;
            last = u[i];
            if (sen && run == 5) begin
                push_e(!last, K_OTH, uf[i]);
                last = !last;
                run  = 1;
            end
        end
        push_e(1'b1, K_OTH, F_TAIL);
        push_e(1'b1, K_ACK, F_TAIL);
        push_e(1'b1, K_OTH, F_TAIL);
        for (int i = 0; i < 7 + IFS; i++) push_e(1'b1, K_OTH, F_TAIL);
    endtask

    function automatic bit drv(input int k, input int force_idx, input bit ack_ok);
        if (k == force_idx) return 1'b0;
        if (exp_kind[k] == K_ACK) return !ack_ok;
        return 1'b1;
    endfunction

    task automatic run_model(input int force_idx, input bit ack_ok, input int rst_at,
                             input bit noise, input string tag);
        int endk;
        logic [5:0] endv;
        bit rx;
        endk = exp_bits.size();
        endv = 6'b101000;
        for (int k = 0; k < exp_bits.size(); k++) begin
            rx = exp_bits[k] & drv(k, force_idx, ack_ok);
            if (exp_kind[k] == K_ARB && exp_bits[k] && !rx) begin
                endk = k + 1; endv = 6'b100100; break;
            end
            if (exp_kind[k] == K_ACK && rx) begin
                endk = k + 1; endv = 6'b100010; break;
            end
            if (exp_kind[k] != K_ACK && rx != exp_bits[k]) begin
                endk = k + 1; endv = 6'b100001; break;
            end
        end

        @(negedge clk);
        ifc.tx_req = 1'b1; ifc.tx_id = m_id; ifc.tx_dlc = m_dlc;
        ifc.tx_data = m_data; ifc.bit_stuffing_EN = m_sen; rx_drive = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= endk; c++) begin
            @(negedge clk);
            if (noise && c < endk) begin
                ifc.tx_req = 1'($urandom);
                ifc.tx_id = 11'($urandom);
                ifc.tx_dlc = 4'($urandom);
                ifc.tx_data = {$urandom, $urandom};
                ifc.bit_stuffing_EN = 1'($urandom);
            end else begin
                ifc.tx_req = 1'b0;
            end
            if (c < endk) begin
                check_vec({tag, "_bit"}, obs(), 8'({exp_bits[c], 1'b1, 4'b0000}));
                if (c == rst_at) begin
                    #1 reset = 1'b0;
                    #1 check_vec({tag, "_rst"}, obs(), 8'(6'b100000));
                    ifc.tx_req = 1'b0;
                    rx_drive = 1'b1;
                    @(negedge clk);
                    reset = 1'b1;
                    @(negedge clk);
                    check_vec({tag, "_rst_idle"}, obs(), 8'(6'b100000));
                    return;
                end
                rx_drive = drv(c, force_idx, ack_ok);
            end else begin
                check_vec({tag, "_end"}, obs(), 8'(endv));
                rx_drive = 1'b1;
            end
        end
        @(negedge clk);
        check_vec({tag, "_idle"}, obs(), 8'(6'b100000));
    endtask

    initial begin
        int f;
        reset = 1'b0;
        rx_drive = 1'b1;
        ifc.tx_req = 1'b0; ifc.tx_id = '0; ifc.tx_dlc = '0;
        ifc.tx_data = '0; ifc.bit_stuffing_EN = 1'b0;
        #12;
        check_vec("reset", obs(), 8'(6'b100000));
        @(negedge clk);
        reset = 1'b1;

        build_model(11'h123, 4'd1, 64'hA500_0000_0000_0000, 1'b0);
        run_model(-1, 1'b1, -1, 1'b0, "plain");

        build_model(11'h555, 4'd0, 64'h0, 1'b1);
        run_model(-1, 1'b1, -1, 1'b0, "stuff");

        build_model(11'h7FF, 4'd2, 64'h1234_5678_9ABC_DEF0, 1'b1);
        run_model(4, 1'b1, -1, 1'b0, "arb");

        build_model(11'h2A1, 4'd3, 64'hDEAD_BEEF_0000_0000, 1'b1);
        run_model(-1, 1'b0, -1, 1'b0, "ack");

        build_model(11'h0F3, 4'd4, 64'hCAFE_F00D_1234_5678, 1'b1);
        f = -1;
        foreach (exp_bits[k])
            if (f < 0 && exp_field[k] == F_CRC && exp_bits[k]) f = k;
        if (f < 0)
            foreach (exp_field[k])
                if (f < 0 && exp_field[k] == F_TAIL) f = k;
        run_model(f, 1'b1, -1, 1'b0, "crcbit");

        build_model(11'h3C5, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b1);
        f = -1;
        foreach (exp_field[k])
            if (f < 0 && exp_field[k] == F_DATA) f = k;
        run_model(-1, 1'b1, f + 10, 1'b0, "rstmid");

        build_model(11'h3C5, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b1);
        run_model(-1, 1'b1, -1, 1'b0, "after_rst");

        build_model(11'h4B2, 4'd12, 64'hF0E1_D2C3_B4A5_9687, 1'b0);
        run_model(-1, 1'b1, -1, 1'b1, "dlc12");

        for (int i = 0; i < 40; i++) begin
            build_model(11'($urandom), 4'($urandom_range(0, 15)),
                        {$urandom, $urandom}, 1'($urandom));
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_bits.size() - 1)) : -1;
            run_model(f, $urandom_range(0, 9) != 0, -1, 1'b1, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/can_frame_tx.md
# can_frame_tx

Transmit-side CAN controller core. It accepts one standard data frame (11-bit ID, 0–8 data bytes) from the host and serialises it onto the shared wired-AND CAN bus `data` line, one bit per `clk`. Along the way it inserts stuff bits, appends CRC-15, checks for arbitration loss and bit errors, and samples the ACK slot. It is the driving counterpart of the bus monitor/receiver side and sits between the host request logic and the bus interface.

## Interface
Parameters
- IFS_BITS, 3: recessive intermission bits sent after EOF, before completion.

Ports
- clk  input  1  bit clock; one CAN bit per cycle.
- reset  input  1  asynchronous, active-low reset.
- tx_req  input  1  frame request; sampled only in IDLE.
- tx_id  input  11  identifier; MSB is sent first.
- tx_dlc  input  4  DLC field, sent verbatim; payload bytes = min(tx_dlc, 8).
- tx_data  input  64  payload; byte [63:56] is sent first, MSB first.
- bit_stuffing_EN  input  1  1 = stuffing on; 0 = no stuff bits inserted.
- bus_rx  input  1  resolved bus value (`data`).
- bus_tx  output  1  value driven onto the wired-AND bus; 1 = recessive.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse: frame completed successfully.
- arb_lost  output  1  one-cycle pulse: arbitration lost.
- ack_err  output  1  one-cycle pulse: ACK slot was recessive.
- bit_err  output  1  one-cycle pulse: readback mismatch outside arbitration and ACK slot.

## Operation
- Reset (asynchronous, `reset`=0): bus_tx=1, tx_busy=0, all pulses 0, FSM=IDLE, stuff run counter=0, CRC=0.
- FSM states and order: IDLE → ARB (SOF, ID, RTR) → CTRL (IDE, r0, DLC) → DATA (skipped if 0 bytes) → CRC (15 bits) → CRC_DEL → ACK_SLOT → ACK_DEL → EOF (7) → IFS (IFS_BITS) → IDLE.
- Field values: SOF=0, RTR=0, IDE=0, r0=0. CRC_DEL, ACK_SLOT (driven), ACK_DEL, EOF and IFS are all 1.
- Latching: tx_id, tx_dlc and tx_data are latched on acceptance. Later changes to them do not affect the frame in flight.
- CRC-15:
  - Polynomial 0x4599, initial value 0.
  - Input is the unstuffed bits SOF through the last data bit.
  - Per bit: nxt = bit ^ crc[14]; crc = {crc[13:0],0}; if nxt, crc ^= 0x4599.
  - Transmitted MSB first.
- Stuffing (when bit_stuffing_EN=1):
  - Applies from SOF through the last CRC bit.
  - After 5 consecutive equal transmitted bits, the complement is inserted.
  - A stuff bit starts a new run of length 1.
  - No stuffing from CRC_DEL onward.
  - bit_stuffing_EN is latched at acceptance.
- Readback: each transmitted bit is compared with bus_rx one edge later.
  - ARB, data bits: bus_tx=1 and bus_rx=0 → arb_lost pulse. The block drives 1 from that edge, returns to IDLE and drops tx_busy. Stuff bits in ARB that mismatch → bit_err.
  - ACK_SLOT: bus_rx=1 → ack_err pulse, abort to IDLE with bus_tx=1. bus_rx=0 → continue.
  - Any other state: mismatch → bit_err pulse, abort to IDLE with bus_tx=1.
- No error frames and no automatic retransmission; the host re-requests.
- tx_req while tx_busy=1 is ignored. It is not queued.

## Timing
- Acceptance at edge E0 (IDLE, tx_req=1): bus_tx=0 (SOF) and tx_busy=1 are visible after E0.
- Bit k is launched at edge E0+k and checked against bus_rx at edge E0+k+1, the same edge that launches bit k+1.
- Unstuffed frame length from SOF through the last IFS bit: 44 + 8·N + IFS_BITS bits (N = payload bytes).
- tx_done:
  - Pulses at the edge that checks the last IFS bit.
  - tx_busy falls at that same edge.
  - With stuffing off: edge E0 + 44 + 8N + IFS_BITS.
- Abort pulses (arb_lost, ack_err, bit_err) coincide with tx_busy falling. The earliest new acceptance is the following edge.
- Simultaneous tx_req and abort edge: the request is ignored, because the FSM is not in IDLE at that edge.
- Reset mid-frame: bus_tx=1 immediately (asynchronously). No pulses are emitted.

## Test plan
- Stuffing off, id=0x123, dlc=1, data byte 0xA5, bus_rx=bus_tx except ACK slot forced 0 → exact 55-bit sequence with correct CRC; tx_done at E0+55; no error pulses.
- Stuffing on, id=0x555, dlc=0 → one recessive stuff bit after DLC bit 2 (run RTR, IDE, r0, DLC3, DLC2 = 0); CRC bits also stuffed per rule; tx_done; no errors.
- Arbitration: id=0x7FF, bus_rx forced 0 during ID bit 3 → arb_lost one cycle at the check edge; bus_tx=1 from that edge; tx_busy=0; no tx_done.
- ACK slot left recessive (bus_rx=1) → ack_err pulse at the ACK check edge; IDLE; no tx_done.
- bus_rx forced 0 during a recessive CRC bit → bit_err; abort. Separately, reset asserted mid-DATA → bus_tx=1 and tx_busy=0 with no clock edge; a new tx_req after release starts a clean frame with CRC=0.
- dlc=12 → DLC field sent as 1100, exactly 8 payload bytes; tx_req pulsed during the frame is ignored.
